// File: rtl/prog_loader_pkg.sv
// Shared widths and state codes for the instruction-memory program loader.
package prog_loader_pkg;

  localparam int unsigned LD_W     = 4;
  localparam int unsigned LD_DW    = 8;
  localparam int unsigned LD_DEPTH = 1 << LD_W;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_CHECK = 2'd2,
    LD_FIN   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in (valid/ready) and instruction RAM write port of the loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int unsigned W  = LD_W,
  parameter int unsigned DW = LD_DW
) ();

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_we;
  logic [W-1:0]  mem_adrs;
  logic [DW-1:0] mem_dat;

  // Host / serial front end: produces the stream, observes the RAM writes.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_adrs,
    input  mem_dat
  );

  // Loader: consumes the stream, drives the RAM write port.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_adrs,
    output mem_dat
  );

endinterface

// File: rtl/prog_loader_checksum.sv
// DW-bit running sum of the loaded words; only built with LOADER_CHECKSUM_EN.
// sum_zero_c reports whether adding din to the current sum gives zero.
`ifdef LOADER_CHECKSUM_EN
module prog_loader_checksum
  import prog_loader_pkg::*;
#(
  parameter int unsigned DW = LD_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          add,
  input  logic [DW-1:0] din,
  output logic          sum_zero_c
);

  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_d;

  // Next accumulator value: clear wins over add.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = DW'(acc_q + din);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_zero_c = (DW'(acc_q + din) == '0);

endmodule
`endif

// File: rtl/prog_loader.sv
// Program loader: writes a DEPTH-word byte stream into instruction RAM from
// address 0 and holds the CPU while doing so. Build option LOADER_CHECKSUM_EN
// adds a trailing checksum byte that must bring the word sum to zero.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned W  = LD_W,
  parameter int unsigned DW = LD_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned DEPTH = 1 << W;
  localparam logic [W-1:0] LAST_ADRS = W'(DEPTH - 1);

  ld_state_e     state_q,    state_d;
  logic [W-1:0]  cnt_q,      cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          mem_we_q,   mem_we_d;
  logic [W-1:0]  mem_adrs_q, mem_adrs_d;
  logic [DW-1:0] mem_dat_q,  mem_dat_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;
  logic          xfer_c;

  assign xfer_c = bus.in_valid & in_ready_q;

`ifdef LOADER_CHECKSUM_EN
  logic err_q, err_d;
  logic ck_clr_c, ck_add_c, ck_zero_c;

  prog_loader_checksum #(.DW(DW)) u_checksum (
    .clk        (clk),
    .reset      (reset),
    .clr        (ck_clr_c),
    .add        (ck_add_c),
    .din        (bus.in_data),
    .sum_zero_c (ck_zero_c)
  );
`endif

  // Next state, counter and registered output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready_q;
    mem_we_d   = 1'b0;
    mem_adrs_d = mem_adrs_q;
    mem_dat_d  = mem_dat_q;
    cpu_hold_d = cpu_hold_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    err_d      = err_q;
    ck_clr_c   = 1'b0;
    ck_add_c   = 1'b0;
`endif

    unique case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d    = LD_LOAD;
          cnt_d      = '0;
          in_ready_d = 1'b1;
          cpu_hold_d = 1'b1;
          busy_d     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          err_d      = 1'b0;
          ck_clr_c   = 1'b1;
`endif
        end
      end

      LD_LOAD: begin
        if (xfer_c) begin
          mem_we_d   = 1'b1;
          mem_adrs_d = cnt_q;
          mem_dat_d  = bus.in_data;
          cnt_d      = cnt_q + W'(1);
`ifdef LOADER_CHECKSUM_EN
          ck_add_c   = 1'b1;
`endif
          if (cnt_q == LAST_ADRS) begin
`ifdef LOADER_CHECKSUM_EN
            // Stay ready for the checksum byte.
            state_d    = LD_CHECK;
`else
            state_d    = LD_FIN;
            in_ready_d = 1'b0;
`endif
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (xfer_c) begin
          in_ready_d = 1'b0;
          if (ck_zero_c) begin
            state_d = LD_FIN;
          end else begin
            // Bad image: keep the CPU held, flag it and go idle.
            state_d = LD_IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
`endif

      LD_FIN: begin
        state_d    = LD_IDLE;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
        busy_d     = 1'b0;
      end

      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LD_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_adrs_q <= '0;
      mem_dat_q  <= '0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      mem_adrs_q <= mem_adrs_d;
      mem_dat_q  <= mem_dat_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Sticky checksum error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.in_ready = in_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_adrs = mem_adrs_q;
  assign bus.mem_dat  = mem_dat_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; checksum scenario built with LOADER_CHECKSUM_EN.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, busy, done, err;

  prog_loader_if bus ();

  prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Write log and RAM image captured from the write port.
  int         log_n = 0;
  logic [3:0] log_adrs [256];
  logic [7:0] log_dat  [256];
  int         log_cyc  [256];
  logic [7:0] ram_m    [16];
  int         done_n   = 0;
  int         done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (log_n < 256) begin
        log_adrs[log_n] = bus.mem_adrs;
        log_dat[log_n]  = bus.mem_dat;
        log_cyc[log_n]  = cyc;
      end
      ram_m[bus.mem_adrs] = bus.mem_dat;
      log_n++;
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte until accepted (bounded).
  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done_n > base) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [22:0] outs;
    reset = 1'b1;
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick();
    tick();
    outs = {bus.in_ready, bus.mem_we, bus.mem_adrs, bus.mem_dat, cpu_hold, busy, done, err};
    tests++;
    if (outs !== 23'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    tick();
    outs = {bus.in_ready, bus.mem_we, bus.mem_adrs, bus.mem_dat, cpu_hold, busy, done, err};
    tests++;
    if (outs !== 23'd0) begin
      fails++;
      $display("FAIL idle_outputs: got %h, want 0", outs);
    end
  endtask

  task automatic test_back_to_back();
    int base, dbase, bad, nok;
    bit ok;
    base = log_n; dbase = done_n; nok = 0;
    pulse_start();
    tests++;
    if ({cpu_hold, busy, bus.in_ready} !== 3'b111) begin
      fails++;
      $display("FAIL b2b_start: hold/busy/ready=%b, want 111", {cpu_hold, busy, bus.in_ready});
    end
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), ok);
      if (!ok) nok++;
    end
    wait_done(dbase, ok);
    tests++;
    if (!ok || nok != 0) begin
      fails++;
      $display("FAIL b2b_handshake: done=%0d stalled_sends=%0d, want 1 and 0", ok, nok);
    end
    tick(); tick();
    tests++;
    if (log_n - base != 16) begin
      fails++;
      $display("FAIL b2b_write_count: got %0d, want 16", log_n - base);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if ({log_adrs[base+i], log_dat[base+i]} !== {4'(i), 8'(i)}) begin
        fails++;
        $display("FAIL b2b_write%0d: adrs/dat %h/%h, want %h/%h",
                 i, log_adrs[base+i], log_dat[base+i], 4'(i), 8'(i));
      end
    end
    bad = 0;
    for (int i = 1; i < 16; i++) if (log_cyc[base+i] - log_cyc[base+i-1] != 1) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL b2b_consecutive: %0d gaps, want 0", bad);
    end
    tests++;
    if (done_n - dbase != 1 || done_cyc != log_cyc[base+15] + 1) begin
      fails++;
      $display("FAIL b2b_done: pulses=%0d cyc=%0d, want 1 at %0d",
               done_n - dbase, done_cyc, log_cyc[base+15] + 1);
    end
    tests++;
    if ({cpu_hold, busy, bus.in_ready, err} !== 4'b0000) begin
      fails++;
      $display("FAIL b2b_release: hold/busy/ready/err=%b, want 0000",
               {cpu_hold, busy, bus.in_ready, err});
    end
  endtask

  task automatic test_stall();
    int base, dbase, bad, nok;
    bit ok;
    base = log_n; dbase = done_n; nok = 0;
    for (int i = 0; i < 16; i++) ram_m[i] = 8'hEE;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(i), ok);
      if (!ok) nok++;
    end
    repeat (3) tick();
    for (int i = 6; i < 16; i++) begin
      send_byte(8'(i), ok);
      if (!ok) nok++;
    end
    wait_done(dbase, ok);
    tick();
    tests++;
    if (!ok || nok != 0 || log_n - base != 16) begin
      fails++;
      $display("FAIL stall_count: done=%0d stalled=%0d writes=%0d, want 1/0/16",
               ok, nok, log_n - base);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (log_adrs[base+i] !== 4'(i)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_adrs: %0d wrong addresses, want 0", bad);
    end
    tests++;
    if (log_cyc[base+6] - log_cyc[base+5] != 4) begin
      fails++;
      $display("FAIL stall_gap: got %0d cycles, want 4", log_cyc[base+6] - log_cyc[base+5]);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram_m[i] !== 8'(i)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_ram: %0d words differ, want 0", bad);
    end
  endtask

  task automatic test_start_midload();
    int base, dbase, bad, nok, rdy, n0;
    bit ok;
    base = log_n; dbase = done_n; nok = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 8) start = 1'b1;
      send_byte(8'(i + 8'h80), ok);
      start = 1'b0;
      if (!ok) nok++;
    end
    wait_done(dbase, ok);
    tick(); tick();
    bad = 0;
    for (int i = 0; i < 16; i++)
      if ({log_adrs[base+i], log_dat[base+i]} !== {4'(i), 8'(i + 8'h80)}) bad++;
    tests++;
    if (nok != 0 || log_n - base != 16 || bad != 0) begin
      fails++;
      $display("FAIL midstart_writes: count=%0d bad=%0d stalled=%0d, want 16/0/0",
               log_n - base, bad, nok);
    end
    tests++;
    if (done_n - dbase != 1) begin
      fails++;
      $display("FAIL midstart_done: got %0d pulses, want 1", done_n - dbase);
    end
    n0 = log_n; rdy = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) rdy++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    tick();
    tests++;
    if (rdy != 0 || log_n != n0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_valid: ready_cycles=%0d writes=%0d busy=%b, want 0/0/0",
               rdy, log_n - n0, busy);
    end
  endtask

  task automatic test_reset_midload();
    int base, dbase, bad, nok;
    bit ok;
    logic [22:0] outs;
    base = log_n; nok = 0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(i + 8'h30), ok);
      if (!ok) nok++;
    end
    reset = 1'b1;
    tick();
    outs = {bus.in_ready, bus.mem_we, bus.mem_adrs, bus.mem_dat, cpu_hold, busy, done, err};
    tests++;
    if (outs !== 23'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got %h, want 0", outs);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (log_n - base != 10 || nok != 0) begin
      fails++;
      $display("FAIL midreset_partial: writes=%0d stalled=%0d, want 10/0", log_n - base, nok);
    end
    base = log_n; dbase = done_n; nok = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i + 8'h40), ok);
      if (!ok) nok++;
    end
    wait_done(dbase, ok);
    tick();
    tests++;
    if (log_adrs[base] !== 4'd0 || log_n - base != 16 || !ok) begin
      fails++;
      $display("FAIL reload_first: adrs=%h writes=%0d done=%0d, want 0/16/1",
               log_adrs[base], log_n - base, ok);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram_m[i] !== 8'(i + 8'h40)) bad++;
    tests++;
    if (bad != 0 || nok != 0) begin
      fails++;
      $display("FAIL reload_ram: %0d words differ, stalled=%0d, want 0/0", bad, nok);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int base, dbase, nok;
    bit ok;
    base = log_n; dbase = done_n; nok = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h01, ok);
      if (!ok) nok++;
    end
    send_byte(8'hF0, ok);
    if (!ok) nok++;
    wait_done(dbase, ok);
    tick();
    tests++;
    if (!ok || err !== 1'b0 || cpu_hold !== 1'b0 || log_n - base != 16 || nok != 0) begin
      fails++;
      $display("FAIL csum_good: done=%0d err=%b hold=%b writes=%0d, want 1/0/0/16",
               ok, err, cpu_hold, log_n - base);
    end
    base = log_n; dbase = done_n; nok = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h01, ok);
      if (!ok) nok++;
    end
    send_byte(8'hF1, ok);
    if (!ok) nok++;
    repeat (4) tick();
    tests++;
    if (err !== 1'b1 || done_n != dbase || cpu_hold !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL csum_bad: err=%b dones=%0d hold=%b busy=%b, want 1/0/1/0",
               err, done_n - dbase, cpu_hold, busy);
    end
    tests++;
    if (log_n - base != 16 || bus.in_ready !== 1'b0 || nok != 0) begin
      fails++;
      $display("FAIL csum_bad_writes: writes=%0d ready=%b, want 16/0",
               log_n - base, bus.in_ready);
    end
  endtask
`else
  task automatic test_no_extra_byte();
    int base, dbase, nok, rdy;
    bit ok;
    base = log_n; dbase = done_n; nok = 0; rdy = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i + 8'h20), ok);
      if (!ok) nok++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (5) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) rdy++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    tick();
    tests++;
    if (rdy != 0 || log_n - base != 16 || nok != 0) begin
      fails++;
      $display("FAIL extra_byte: ready_cycles=%0d writes=%0d, want 0/16", rdy, log_n - base);
    end
    tests++;
    if (err !== 1'b0 || done_n - dbase != 1) begin
      fails++;
      $display("FAIL extra_status: err=%b dones=%0d, want 0/1", err, done_n - dbase);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_stall();
    test_start_midload();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_no_extra_byte();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
